// File: rtl/register_file_param.sv
// ---------------------------------------------------------------------------
// register_file_param
//   Parametrised register file with two read ports and one write port. It sits
//   between decode (read addresses) and writeback (write port). Options:
//   - a hardwired-zero entry 0
//   - forwarding of same-cycle write data to a matching read port
//   - a background scrub sequencer that clears one entry per cycle, so the
//     array can be emptied without a full reset
//
// Ports
//   clk          rising-edge clock
//   clr_n        synchronous active-low reset (clears array, FSM, flags)
//   Write_En     write strobe, sampled at posedge
//   Write_Addr   write address
//   Write_Data   write data
//   Read_Addr_A  read address, port A
//   Read_Addr_B  read address, port B
//   OutA         port A read data (combinational)
//   OutB         port B read data (combinational)
//   scrub_req    start a sequential clear; only honoured while idle
//   busy         high while a scrub is in progress (registered)
//   write_drop   one-cycle pulse: a write arrived during a scrub and was lost
// ---------------------------------------------------------------------------
module register_file_param #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              Write_En,
   input  logic [ADDR_W-1:0] Write_Addr,
   input  logic [DATA_W-1:0] Write_Data,
   input  logic [ADDR_W-1:0] Read_Addr_A,
   input  logic [ADDR_W-1:0] Read_Addr_B,
   output logic [DATA_W-1:0] OutA,
   output logic [DATA_W-1:0] OutB,
   input  logic              scrub_req,
   output logic              busy,
   output logic              write_drop
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SCRUB = 1'b1
   } state_t;

   state_t            state_r;
   logic [ADDR_W-1:0] ptr_r;
   logic              busy_r;
   logic              write_drop_r;
   logic [DATA_W-1:0] mem_r [DEPTH];

   logic              fwd_ok_s;
   logic              write_ok_s;
   logic [DATA_W-1:0] out_a_s;
   logic [DATA_W-1:0] out_b_s;

   // Read mux for one port. The hardwired-zero entry takes priority over
   // forwarding, so a write aimed at entry 0 never becomes visible.
   function automatic logic [DATA_W-1:0] read_port(
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] stored,
      input logic              fwd_ok,
      input logic [ADDR_W-1:0] wr_addr,
      input logic [DATA_W-1:0] wr_data
   );
      logic [DATA_W-1:0] result;
      if ((ZERO_REG != 0) && (addr == {ADDR_W{1'b0}})) begin
         result = {DATA_W{1'b0}};
      end else if (fwd_ok && (wr_addr == addr)) begin
         result = wr_data;
      end else begin
         result = stored;
      end
      return result;
   endfunction

   // Forwarding and write acceptance qualifiers; no forwarding while scrubbing.
   always_comb begin
      fwd_ok_s   = 1'b0;
      write_ok_s = 1'b0;
      if ((BYPASS != 0) && (state_r == ST_IDLE) && Write_En) begin
         fwd_ok_s = 1'b1;
      end else begin
         fwd_ok_s = 1'b0;
      end
      // A write to the hardwired-zero entry is ignored silently (not a drop).
      if (Write_En && !((ZERO_REG != 0) && (Write_Addr == {ADDR_W{1'b0}}))) begin
         write_ok_s = 1'b1;
      end else begin
         write_ok_s = 1'b0;
      end
   end

   // Combinational read ports.
   always_comb begin
      out_a_s = read_port(Read_Addr_A, mem_r[Read_Addr_A], fwd_ok_s, Write_Addr, Write_Data);
      out_b_s = read_port(Read_Addr_B, mem_r[Read_Addr_B], fwd_ok_s, Write_Addr, Write_Data);
   end

   assign OutA       = out_a_s;
   assign OutB       = out_b_s;
   assign busy       = busy_r;
   assign write_drop = write_drop_r;

   // Array, scrub sequencer and status flags; reset wins over writes and scrubs.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
         state_r      <= ST_IDLE;
         ptr_r        <= {ADDR_W{1'b0}};
         busy_r       <= 1'b0;
         write_drop_r <= 1'b0;
      end else begin
         // busy_r mirrors the SCRUB state, so this flags writes lost to a scrub.
         write_drop_r <= Write_En & busy_r;
         case (state_r)
            ST_IDLE: begin
               if (write_ok_s) begin
                  mem_r[Write_Addr] <= Write_Data;
               end
               // A write in the request cycle is still taken (above).
               if (scrub_req) begin
                  state_r <= ST_SCRUB;
                  busy_r  <= 1'b1;
                  ptr_r   <= {ADDR_W{1'b0}};
               end
            end
            ST_SCRUB: begin
               // scrub_req is deliberately ignored here: no queueing or restart.
               mem_r[ptr_r] <= {DATA_W{1'b0}};
               if (ptr_r == LAST_PTR) begin
                  ptr_r   <= {ADDR_W{1'b0}};
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  ptr_r <= ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               ptr_r   <= {ADDR_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_register_file_param.sv
// ---------------------------------------------------------------------------
// tb_register_file_param
//   Directed bench for register_file_param. Three instances share the stimulus:
//   the default build (bypass on), a bypass-off build and a hardwired-zero
//   build. Expected values are pushed to a scoreboard queue when a step is
//   driven and popped when the corresponding output is sampled.
// ---------------------------------------------------------------------------
module tb_register_file_param;

   logic        clk = 1'b0;
   logic        clr_n;
   logic        Write_En;
   logic [2:0]  Write_Addr;
   logic [15:0] Write_Data;
   logic [2:0]  Read_Addr_A;
   logic [2:0]  Read_Addr_B;
   logic        scrub_req;

   logic [15:0] a_def, b_def, a_nb, b_nb, a_z, b_z;
   logic        busy_def, busy_nb, busy_z;
   logic        drop_def, drop_nb, drop_z;

   typedef struct {
      string       tag;
      logic [15:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   logic [15:0] fill [8];

   always #5 clk = ~clk;

   register_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(1)) dut (
      .clk(clk), .clr_n(clr_n), .Write_En(Write_En), .Write_Addr(Write_Addr),
      .Write_Data(Write_Data), .Read_Addr_A(Read_Addr_A), .Read_Addr_B(Read_Addr_B),
      .OutA(a_def), .OutB(b_def), .scrub_req(scrub_req), .busy(busy_def),
      .write_drop(drop_def));

   register_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) dut_nb (
      .clk(clk), .clr_n(clr_n), .Write_En(Write_En), .Write_Addr(Write_Addr),
      .Write_Data(Write_Data), .Read_Addr_A(Read_Addr_A), .Read_Addr_B(Read_Addr_B),
      .OutA(a_nb), .OutB(b_nb), .scrub_req(scrub_req), .busy(busy_nb),
      .write_drop(drop_nb));

   register_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_z (
      .clk(clk), .clr_n(clr_n), .Write_En(Write_En), .Write_Addr(Write_Addr),
      .Write_Data(Write_Data), .Read_Addr_A(Read_Addr_A), .Read_Addr_B(Read_Addr_B),
      .OutA(a_z), .OutB(b_z), .scrub_req(scrub_req), .busy(busy_z),
      .write_drop(drop_z));

   // Queue an expected value.
   task automatic push(input string tag, input logic [15:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      exp_q.push_back(e);
   endtask

   // Pop the oldest expectation and compare it with an observed value.
   task automatic chk(input logic [15:0] obs);
      exp_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $error("FAIL scoreboard_empty: observed %h with nothing expected", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
         end
      end
   endtask

   // One write request at the next edge (inputs change at negedge).
   task automatic wr(input logic [2:0] addr, input logic [15:0] data);
      @(negedge clk);
      Write_En   = 1'b1;
      Write_Addr = addr;
      Write_Data = data;
      @(negedge clk);
      Write_En   = 1'b0;
   endtask

   initial begin
      int guard;
      fill[0] = 16'h0012; fill[1] = 16'h0034; fill[2] = 16'h0056; fill[3] = 16'h0078;
      fill[4] = 16'h009A; fill[5] = 16'h00BC; fill[6] = 16'h00DE; fill[7] = 16'h00F0;

      clr_n = 1'b0; Write_En = 1'b0; Write_Addr = 3'd0; Write_Data = 16'h0000;
      Read_Addr_A = 3'd0; Read_Addr_B = 3'd0; scrub_req = 1'b0;

      // ---- reset: 5 edges with clr_n low
      repeat (5) @(negedge clk);
      clr_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         Read_Addr_A = 3'(i);
         push($sformatf("rst_mem%0d", i), 16'h0000);
         #1 chk(a_def);
      end
      push("rst_busy", 16'h0000);  chk({15'd0, busy_def});
      push("rst_drop", 16'h0000);  chk({15'd0, drop_def});

      // ---- 1: fill and read back on port A
      for (int i = 0; i < 8; i++) wr(3'(i), fill[i]);
      for (int i = 0; i < 8; i++) begin
         Read_Addr_A = 3'(i);
         push($sformatf("fill_a%0d", i), fill[i]);
         #1 chk(a_def);
      end
      Read_Addr_A = 3'd0;
      push("fill_nb_a0", 16'h0012); #1 chk(a_nb);
      push("fill_z_a0", 16'h0000);  chk(a_z);

      // ---- 2: same-cycle write/read on both ports
      @(negedge clk);
      Write_En = 1'b1; Write_Addr = 3'd3; Write_Data = 16'hAAAA;
      Read_Addr_A = 3'd3; Read_Addr_B = 3'd3;
      push("byp_a", 16'hAAAA);      #1 chk(a_def);
      push("byp_b", 16'hAAAA);      chk(b_def);
      push("nobyp_a_pre", 16'h0078); chk(a_nb);
      push("nobyp_b_pre", 16'h0078); chk(b_nb);
      @(negedge clk);
      Write_En = 1'b0;
      push("nobyp_a_post", 16'hAAAA); #1 chk(a_nb);
      push("byp_a_post", 16'hAAAA);   chk(a_def);

      // ---- 3: hardwired zero entry
      @(negedge clk);
      Write_En = 1'b1; Write_Addr = 3'd0; Write_Data = 16'hFFFF;
      Read_Addr_A = 3'd0;
      push("zero_a_pre", 16'h0000);  #1 chk(a_z);
      push("def_a0_byp", 16'hFFFF);  chk(a_def);
      @(negedge clk);
      Write_En = 1'b0;
      push("zero_a_post", 16'h0000); #1 chk(a_z);
      push("zero_drop", 16'h0000);   chk({15'd0, drop_z});
      push("def_a0_post", 16'hFFFF); chk(a_def);
      wr(3'd1, 16'h5555);
      Read_Addr_B = 3'd1;
      push("zero_b1", 16'h5555);     #1 chk(b_z);

      // ---- 4: scrub timing; scrub_req held for one cycle mid-scrub
      // contents now: FFFF 5555 0056 AAAA 009A 00BC 00DE 00F0
      fill[0] = 16'hFFFF; fill[1] = 16'h5555; fill[3] = 16'hAAAA;
      @(negedge clk);
      scrub_req = 1'b1;
      @(negedge clk);
      scrub_req = 1'b0;
      for (int k = 0; k < 8; k++) begin
         Read_Addr_A = 3'(k);
         scrub_req   = (k == 2);
         push($sformatf("scrub_busy%0d", k), 16'h0001); #1 chk({15'd0, busy_def});
         push($sformatf("scrub_pre%0d", k), fill[k]);   chk(a_def);
         @(negedge clk);
         scrub_req = 1'b0;
         push($sformatf("scrub_post%0d", k), 16'h0000); #1 chk(a_def);
      end
      push("scrub_busy_end", 16'h0000); chk({15'd0, busy_def});
      @(negedge clk);
      push("scrub_no_restart", 16'h0000); #1 chk({15'd0, busy_def});
      for (int i = 0; i < 8; i++) begin
         Read_Addr_B = 3'(i);
         push($sformatf("scrub_all%0d", i), 16'h0000);
         #1 chk(b_def);
      end

      // ---- 5: write in request cycle accepted, write during scrub dropped
      @(negedge clk);
      scrub_req = 1'b1; Write_En = 1'b1; Write_Addr = 3'd5; Write_Data = 16'h1234;
      @(negedge clk);
      scrub_req = 1'b0; Write_En = 1'b0; Read_Addr_A = 3'd5;
      push("req_wr_taken", 16'h1234); #1 chk(a_def);
      push("req_wr_nodrop", 16'h0000); chk({15'd0, drop_def});
      @(negedge clk);
      Write_En = 1'b1; Write_Addr = 3'd5; Write_Data = 16'h4321;
      push("scrub_no_fwd", 16'h1234); #1 chk(a_def);
      @(negedge clk);
      Write_En = 1'b0;
      push("drop_pulse", 16'h0001);   #1 chk({15'd0, drop_def});
      push("drop_kept_old", 16'h1234); chk(a_def);
      @(negedge clk);
      push("drop_one_cycle", 16'h0000); #1 chk({15'd0, drop_def});
      guard = 0;
      while (busy_def && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      push("scrub5_done", 16'h0000);  #1 chk({15'd0, busy_def});
      push("scrub5_mem5", 16'h0000);  chk(a_def);

      // ---- 6: reset during scrub, then restart from entry 0
      wr(3'd7, 16'h7777);
      wr(3'd4, 16'hBEEF);
      @(negedge clk);
      scrub_req = 1'b1;
      @(negedge clk);
      scrub_req = 1'b0;
      repeat (2) @(negedge clk);
      clr_n = 1'b0;
      @(negedge clk);
      clr_n = 1'b1;
      push("rst_abort_busy", 16'h0000); #1 chk({15'd0, busy_def});
      for (int i = 0; i < 8; i++) begin
         Read_Addr_A = 3'(i);
         push($sformatf("rst_abort_mem%0d", i), 16'h0000);
         #1 chk(a_def);
      end
      wr(3'd0, 16'h0A0A);
      wr(3'd3, 16'h3333);
      @(negedge clk);
      scrub_req = 1'b1;
      @(negedge clk);
      scrub_req = 1'b0; Read_Addr_A = 3'd0; Read_Addr_B = 3'd3;
      push("restart_busy", 16'h0001); #1 chk({15'd0, busy_def});
      push("restart_a0_pre", 16'h0A0A); chk(a_def);
      @(negedge clk);
      push("restart_a0_clr", 16'h0000); #1 chk(a_def);
      push("restart_b3_kept", 16'h3333); chk(b_def);
      guard = 0;
      while (busy_def && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      push("restart_done", 16'h0000); #1 chk({15'd0, busy_def});
      push("restart_b3_clr", 16'h0000); chk(b_def);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
